avg_buffer: RTL and testbench

- Downstream stage of the 8-sample accumulator block.
- Accepts the accumulator's 11-bit sums on its valid_out/data_out pair and converts each to a rounded 8-bit average (sum/8).
- Buffers averages in a small first-word-fall-through FIFO toward a ready/valid consumer.
- Tracks a sticky overflow flag and the running maximum average since reset.

---
 rtl/avg_buffer.sv | 74 +++++++
 tb/tb_avg_buffer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/avg_buffer.sv
// rtl/avg_buffer.sv - rounds accumulator sums to averages and buffers them in a FWFT FIFO
// Tracks a sticky overflow flag and the largest average accepted since reset.
module avg_buffer #(
  parameter int IN_W  = 11,
  parameter int SHIFT = 3,
  parameter int DEPTH = 4,
  parameter int OUT_W = IN_W - SHIFT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_in,
  input  logic [IN_W-1:0]            data_in,
  input  logic                       ready_in,
  output logic                       valid_out,
  output logic [OUT_W-1:0]           data_out,
  output logic                       full_out,
  output logic                       empty_out,
  output logic [$clog2(DEPTH):0]     count_out,
  output logic                       ovf_out,
  output logic [OUT_W-1:0]           max_out
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [IN_W:0] HALF = (IN_W+1)'(1) << (SHIFT-1);

  logic [OUT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             ovf;
  logic [OUT_W-1:0] max_q;

  logic [IN_W:0]    rounded;
  logic [OUT_W-1:0] avg;
  logic             push, pop;

  // Rounded divide at one extra bit so the +half never wraps; anything above OUT_W saturates.
  always_comb begin
    rounded = ({1'b0, data_in} + HALF) >> SHIFT;
    avg     = (|rounded[IN_W:OUT_W]) ? {OUT_W{1'b1}} : rounded[OUT_W-1:0];
  end

  assign empty_out = (count == '0);
  assign full_out  = (count == (AW+1)'(DEPTH));
  assign valid_out = !empty_out;
  assign count_out = count;
  assign ovf_out   = ovf;
  assign max_out   = max_q;
  assign data_out  = empty_out ? '0 : mem[rd_ptr];

  assign pop  = valid_out && ready_in;
  assign push = valid_in && (!full_out || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= avg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      max_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (valid_in && !push) ovf <= 1'b1;
      if (push && (avg > max_q)) max_q <= avg;
    end
  end

endmodule

// File: tb/tb_avg_buffer.sv
// tb/tb_avg_buffer.sv - directed self-checking bench for avg_buffer
module tb_avg_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_in = 1'b0;
  logic [10:0] data_in = '0;
  logic        ready_in = 1'b0;
  logic        valid_out;
  logic [7:0]  data_out;
  logic        full_out;
  logic        empty_out;
  logic [2:0]  count_out;
  logic        ovf_out;
  logic [7:0]  max_out;

  int checks = 0;
  int errors = 0;

  avg_buffer dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in), .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .full_out(full_out), .empty_out(empty_out),
    .count_out(count_out), .ovf_out(ovf_out), .max_out(max_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input int sum);
    valid_in = 1'b1;
    data_in  = 11'(sum);
    step();
    valid_in = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  int sums6 [10] = '{24, 2047, 8, 100, 500, 1000, 7, 3, 1500, 64};
  int avgs6 [10] = '{3, 255, 1, 13, 63, 125, 1, 0, 188, 8};
  int max6  [3]  = '{3, 255, 255};

  initial begin
    #2 rst = 1'b1;
    #1;
    check("init_valid", valid_out, 0);
    check("init_empty", empty_out, 1);
    check("init_count", count_out, 0);
    check("init_max", max_out, 0);
    step();
    rst = 1'b0;

    // single sample
    push_one(40);
    check("s_valid", valid_out, 1);
    check("s_data", data_out, 5);
    check("s_count", count_out, 1);
    ready_in = 1'b1;
    step();
    ready_in = 1'b0;
    check("s_empty", empty_out, 1);
    check("s_data0", data_out, 0);

    // rounding and saturation
    push_one(43);
    push_one(44);
    push_one(0);
    push_one(2047);
    check("r_full", full_out, 1);
    ready_in = 1'b1;
    check("r_d0", data_out, 5);  step();
    check("r_d1", data_out, 6);  step();
    check("r_d2", data_out, 0);  step();
    check("r_d3", data_out, 255); step();
    check("r_empty", empty_out, 1);
    ready_in = 1'b0;

    // async reset mid-operation
    push_one(80);
    push_one(80);
    check("rst_pre_count", count_out, 2);
    #2 rst = 1'b1;
    #1;
    check("rst_valid", valid_out, 0);
    check("rst_count", count_out, 0);
    check("rst_ovf", ovf_out, 0);
    check("rst_max", max_out, 0);
    #1 rst = 1'b0;
    step();
    check("rst_post_empty", empty_out, 1);

    // fill and overflow
    push_one(8);
    push_one(16);
    push_one(24);
    push_one(32);
    check("f_full", full_out, 1);
    check("f_count", count_out, 4);
    push_one(80);
    check("f_ovf", ovf_out, 1);
    check("f_max", max_out, 4);
    check("f_count_drop", count_out, 4);
    ready_in = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("f_drain", data_out, i);
      step();
    end
    ready_in = 1'b0;
    check("f_empty", empty_out, 1);
    check("f_ovf_hold", ovf_out, 1);

    // full with concurrent push and pop
    pulse_reset();
    push_one(8);
    push_one(16);
    push_one(24);
    push_one(32);
    ready_in = 1'b1;
    push_one(40);
    check("c_count", count_out, 4);
    check("c_ovf", ovf_out, 0);
    for (int i = 2; i <= 5; i++) begin
      check("c_drain", data_out, i);
      step();
    end
    check("c_empty", empty_out, 1);

    // wrap and running max with streaming pushes
    pulse_reset();
    ready_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_one(sums6[i]);
      check("w_data", data_out, avgs6[i]);
      check("w_count", count_out, 1);
      if (i < 3) check("w_max", max_out, max6[i]);
    end
    step();
    check("w_empty", empty_out, 1);
    check("w_ovf", ovf_out, 0);
    check("w_max_final", max_out, 255);
    ready_in = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
